// File: rtl/dda_line_stepper_pkg.sv
// Shared state encoding and default sizing for the symmetric-DDA line stepper.
package dda_line_stepper_pkg;

    localparam int DFLT_COORD_W = 9;
    localparam int DFLT_FRAC_W  = 11;
    localparam int DFLT_ACC_W   = DFLT_COORD_W + DFLT_FRAC_W + 1;
    localparam int DFLT_SHIFT_W = $clog2(DFLT_COORD_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } dda_state_t;

endpackage

// File: rtl/dda_arith_shift.sv
// Combinational signed arithmetic right shift of a fixed-point delta by the
// normalisation count n.
module dda_arith_shift
    import dda_line_stepper_pkg::*;
#(
    parameter int ACC_W   = DFLT_ACC_W,
    parameter int SHIFT_W = DFLT_SHIFT_W
) (
    input  logic [ACC_W-1:0]   din,
    input  logic [SHIFT_W-1:0] sh,
    output logic [ACC_W-1:0]   dout
);

    assign dout = $signed(din) >>> sh;

endmodule

// File: rtl/dda_line_stepper.sv
// Symmetric-DDA line walker: normalises the major delta to a power of two and
// emits 2^n+1 pixels over a valid/ready link. Optional DDA_DEDUP_EN skips
// pixels that repeat the previously emitted one.
module dda_line_stepper
    import dda_line_stepper_pkg::*;
#(
    parameter int COORD_W = DFLT_COORD_W,
    parameter int FRAC_W  = DFLT_FRAC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               done
);

    localparam int ACC_W   = COORD_W + FRAC_W + 1;
    localparam int SHIFT_W = $clog2(COORD_W + 1);
    localparam int DLT_W   = COORD_W + 1;
    localparam int CNT_W   = COORD_W + 1;

    dda_state_t state_reg, state_next;

    logic [COORD_W-1:0] x0_reg, x0_next, y0_reg, y0_next, m_reg, m_next;
    logic [DLT_W-1:0]   dx_reg, dx_next, dy_reg, dy_next;
    logic [SHIFT_W-1:0] n_reg, n_next;
    logic [CNT_W-1:0]   step_reg, step_next, last_reg, last_next;
    logic [ACC_W-1:0]   accx_reg, accx_next, accy_reg, accy_next;
    logic [ACC_W-1:0]   incx_reg, incx_next, incy_reg, incy_next;

    logic [DLT_W-1:0]   dx_in, dy_in, adx, ady;
    logic [COORD_W-1:0] m_in;
    logic [CNT_W-1:0]   pow_n;
    logic               dup, emit, xfer;

    assign dx_in = {1'b0, x1} - {1'b0, x0};
    assign dy_in = {1'b0, y1} - {1'b0, y0};
    assign adx   = dx_in[DLT_W-1] ? -dx_in : dx_in;
    assign ady   = dy_in[DLT_W-1] ? -dy_in : dy_in;
    assign m_in  = (adx >= ady) ? adx[COORD_W-1:0] : ady[COORD_W-1:0];
    assign pow_n = CNT_W'(1) << n_reg;

    // Deltas scaled into the accumulator's fixed-point format, then divided by 2^n.
    logic [ACC_W-1:0] dlt_ext [2];
    logic [ACC_W-1:0] inc_sh  [2];
    assign dlt_ext[0] = {dx_reg, {FRAC_W{1'b0}}};
    assign dlt_ext[1] = {dy_reg, {FRAC_W{1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_shift
            dda_arith_shift #(
                .ACC_W   (ACC_W),
                .SHIFT_W (SHIFT_W)
            ) u_shift (
                .din  (dlt_ext[gi]),
                .sh   (n_reg),
                .dout (inc_sh[gi])
            );
        end
    endgenerate

    assign pix_x = accx_reg[FRAC_W +: COORD_W];
    assign pix_y = accy_reg[FRAC_W +: COORD_W];

`ifdef DDA_DEDUP_EN
    logic [COORD_W-1:0] prevx_reg, prevx_next, prevy_reg, prevy_next;
    assign dup = (step_reg != '0) && (pix_x == prevx_reg) && (pix_y == prevy_reg);
`else
    assign dup = 1'b0;
`endif

    assign emit      = (state_reg == STEP) && !dup;
    assign pix_valid = emit;
    assign xfer      = emit && pix_ready;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        x0_next    = x0_reg;
        y0_next    = y0_reg;
        m_next     = m_reg;
        dx_next    = dx_reg;
        dy_next    = dy_reg;
        n_next     = n_reg;
        step_next  = step_reg;
        last_next  = last_reg;
        accx_next  = accx_reg;
        accy_next  = accy_reg;
        incx_next  = incx_reg;
        incy_next  = incy_reg;
`ifdef DDA_DEDUP_EN
        prevx_next = prevx_reg;
        prevy_next = prevy_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    x0_next    = x0;
                    y0_next    = y0;
                    dx_next    = dx_in;
                    dy_next    = dy_in;
                    m_next     = m_in;
                    n_next     = '0;
                    state_next = NORM;
                end
            end
            NORM: begin
                if (pow_n >= {1'b0, m_reg}) begin
                    incx_next  = inc_sh[0];
                    incy_next  = inc_sh[1];
                    // Start half a pixel in so that truncation rounds to nearest.
                    accx_next  = {1'b0, x0_reg, 1'b1, {(FRAC_W-1){1'b0}}};
                    accy_next  = {1'b0, y0_reg, 1'b1, {(FRAC_W-1){1'b0}}};
                    step_next  = '0;
                    last_next  = (m_reg == '0) ? '0 : pow_n;
                    state_next = STEP;
                end else begin
                    n_next = n_reg + 1'b1;
                end
            end
            STEP: begin
                if (xfer || dup) begin
                    if (step_reg == last_reg) begin
                        state_next = DONE;
                    end else begin
                        accx_next = accx_reg + incx_reg;
                        accy_next = accy_reg + incy_reg;
                        step_next = step_reg + 1'b1;
                    end
                end
`ifdef DDA_DEDUP_EN
                if (xfer) begin
                    prevx_next = pix_x;
                    prevy_next = pix_y;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            x0_reg    <= '0;
            y0_reg    <= '0;
            m_reg     <= '0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            n_reg     <= '0;
            step_reg  <= '0;
            last_reg  <= '0;
            accx_reg  <= '0;
            accy_reg  <= '0;
            incx_reg  <= '0;
            incy_reg  <= '0;
`ifdef DDA_DEDUP_EN
            prevx_reg <= '0;
            prevy_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            x0_reg    <= x0_next;
            y0_reg    <= y0_next;
            m_reg     <= m_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            n_reg     <= n_next;
            step_reg  <= step_next;
            last_reg  <= last_next;
            accx_reg  <= accx_next;
            accy_reg  <= accy_next;
            incx_reg  <= incx_next;
            incy_reg  <= incy_next;
`ifdef DDA_DEDUP_EN
            prevx_reg <= prevx_next;
            prevy_reg <= prevy_next;
`endif
        end
    end

endmodule

// File: tb/tb_dda_line_stepper.sv
// Scoreboard bench for dda_line_stepper: a rational-arithmetic line model
// fills an expectation queue; a negedge monitor pops and compares transfers.
module tb_dda_line_stepper;

    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [CW-1:0] x0_i = '0, y0_i = '0, x1_i = '0, y1_i = '0;
    logic          busy, pix_valid, done;
    logic [CW-1:0] pix_x, pix_y;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int line_xfers = 0;
    int done_count = 0;
    int last_xfer_cyc = -10;
    int cyc = 0;
    int ready_mode = 0;
    int stall_left = 0;
    bit held = 1'b0;
    logic [CW-1:0] held_x = '0, held_y = '0;

    dda_line_stepper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0_i),
        .y0        (y0_i),
        .x1        (x1_i),
        .y1        (y1_i),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int pack_xy(input int x, input int y);
        return (x << 16) | y;
    endfunction

    // Pixel k lies at endpoint0 + 0.5 + k*delta/2^n, floored.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              output int cnt, output int n);
        int dx, dy, m, last, den, px, py, ppx, ppy;
        dx = x1 - x0;
        dy = y1 - y0;
        m  = (dx < 0) ? -dx : dx;
        if (((dy < 0) ? -dy : dy) > m) m = (dy < 0) ? -dy : dy;
        n = 0;
        while ((1 << n) < m) n++;
        last = (m == 0) ? 0 : (1 << n);
        den  = 2 << n;
        cnt  = 0;
        ppx  = -1;
        ppy  = -1;
        for (int k = 0; k <= last; k++) begin
            px = (x0 * den + (1 << n) + 2 * k * dx) / den;
            py = (y0 * den + (1 << n) + 2 * k * dy) / den;
`ifdef DDA_DEDUP_EN
            if (k > 0 && px == ppx && py == ppy) continue;
`endif
            exp_q.push_back(pack_xy(px, py));
            cnt++;
            ppx = px;
            ppy = py;
        end
    endtask

    // Monitor: compare every accepted pixel, output stability under stall, done timing.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", int'(pix_valid), 1);
                    check("hold_xy", pack_xy(int'(pix_x), int'(pix_y)), pack_xy(int'(held_x), int'(held_y)));
                end
                held   = pix_valid && !pix_ready;
                held_x = pix_x;
                held_y = pix_y;
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_pixel", pack_xy(int'(pix_x), int'(pix_y)), -1);
                    else
                        check("pixel", pack_xy(int'(pix_x), int'(pix_y)), exp_q.pop_front());
                    line_xfers++;
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_count++;
                    check("done_queue_empty", exp_q.size(), 0);
                    check("done_timing", cyc, last_xfer_cyc + 1);
                end
            end
        end
    end

    // Ready driver: always-ready, random, or a scripted 3-cycle stall on pixel 2.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (pix_valid && line_xfers == 1 && stall_left > 0) begin
                        pix_ready = 1'b0;
                        stall_left--;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic run_line(input int x0, input int y0, input int x1, input int y1, input bit poke);
        int cnt, n, lat, t, d0;
        t = 0;
        while (busy && t < 5000) begin
            @(posedge clk);
            t++;
        end
        model_line(x0, y0, x1, y1, cnt, n);
        @(posedge clk);
        #1;
        line_xfers = 0;
        d0 = done_count;
        x0_i = CW'(x0);
        y0_i = CW'(y0);
        x1_i = CW'(x1);
        y1_i = CW'(y1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x0_i = CW'($urandom_range(0, 511));
        y0_i = CW'($urandom_range(0, 511));
        x1_i = CW'($urandom_range(0, 511));
        y1_i = CW'($urandom_range(0, 511));
        check("busy_after_start", int'(busy), 1);
        lat = 1;
        while (!pix_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_pixel_latency", lat, n + 2);
        if (poke) begin
            x0_i = CW'($urandom_range(0, 511));
            x1_i = CW'($urandom_range(0, 511));
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        t = 0;
        while (done_count == d0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("done_seen", int'(done_count != d0), 1);
        #1;
        check("busy_after_done", int'(busy), 0);
        check("pixel_count", line_xfers, cnt);
        $display("line (%0d,%0d)->(%0d,%0d) n=%0d pixels=%0d latency=%0d", x0, y0, x1, y1, n, line_xfers, lat);
    endtask

    initial begin
        int cnt, n, t;
        int ax, ay, bx, by;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(pix_valid), 0);
        check("reset_done", int'(done), 0);
        check("reset_xy", pack_xy(int'(pix_x), int'(pix_y)), 0);
        rst = 1'b0;

        ready_mode = 0;
        run_line(0, 0, 4, 2, 1'b0);
        run_line(5, 5, 5, 5, 1'b0);
        run_line(10, 3, 7, 3, 1'b0);
        run_line(0, 0, 511, 0, 1'b0);

        ready_mode = 2;
        stall_left = 3;
        run_line(0, 0, 4, 2, 1'b1);
        check("stall_applied", stall_left, 0);

        // Mid-line reset on the third pixel of (0,0)->(4,4).
        ready_mode = 0;
        @(posedge clk);
        #1;
        model_line(0, 0, 4, 4, cnt, n);
        line_xfers = 0;
        x0_i = 0; y0_i = 0; x1_i = 4; y1_i = 4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (line_xfers < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_reached_pixel3", int'(line_xfers >= 2), 1);
        @(posedge clk);
        #3;
        check("rst_pre_valid", int'(pix_valid), 1);
        check("rst_pre_xy", pack_xy(int'(pix_x), int'(pix_y)), pack_xy(2, 2));
        rst = 1'b1;
        #1;
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_valid", int'(pix_valid), 0);
        check("rst_async_done", int'(done), 0);
        check("rst_async_xy", pack_xy(int'(pix_x), int'(pix_y)), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_line(3, 7, 9, 1, 1'b0);

        ready_mode = 1;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                ax = 200 + $urandom_range(0, 15);
                ay = 300 + $urandom_range(0, 15);
                bx = 200 + $urandom_range(0, 15);
                by = 300 + $urandom_range(0, 15);
            end else begin
                ax = $urandom_range(0, 511);
                ay = $urandom_range(0, 511);
                bx = $urandom_range(0, 511);
                by = $urandom_range(0, 511);
            end
            run_line(ax, ay, bx, by, (i % 4) == 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("idle_at_end", int'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dda_line_stepper.md
Name: dda_line_stepper

Overview:
- Symmetric-DDA line generator for the scan-conversion datapath.
- Accepts two screen endpoints and computes signed deltas and the normalisation shift count n.
- Produces the per-step fixed-point increments as delta arithmetically right-shifted by n.
- Walks the line, emitting one pixel coordinate per accepted valid/ready transfer to the downstream pixel writer.

Parameters:
- COORD_W, 9, unsigned screen coordinate width.
- FRAC_W, 11, fractional bits of position accumulators. Constraint: FRAC_W >= COORD_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  line request. Sampled only when busy=0.
- x0, y0  in  COORD_W  start point.
- x1, y1  in  COORD_W  end point.
- busy  out  1  high from the cycle after start is accepted until done.
- pix_valid  out  1  pix_x/pix_y hold a pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x, pix_y  out  COORD_W  pixel coordinate.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: state IDLE; busy, pix_valid, done, pix_x, pix_y, n, step counter and accumulators all 0. Reset asserted mid-line discards the line immediately.
- Widths:
  - dx = x1-x0 and dy = y1-y0, signed COORD_W+1.
  - m = max(|dx|,|dy|).
  - Accumulators are signed, COORD_W+FRAC_W+1 bits.
  - inc = (sign-extended delta <<< FRAC_W) >>> n. This is an arithmetic shift and is exact because FRAC_W >= n.
- IDLE: busy=0. On start=1, capture endpoints, dx, dy, m; set n=0; go to NORM. Endpoint inputs are don't-care after capture.
- NORM: one cycle per trial.
  - If (1<<n) >= m: compute incx/incy, set accx = x0<<FRAC_W + 2^(FRAC_W-1) (same for y), set step count=0, go to STEP.
  - Otherwise n++.
  - m=0 gives n=0.
  - NORM lasts n+1 cycles; the first pix_valid appears n+2 cycles after the start edge.
- STEP:
  - pix_valid=1; pix_x = accx>>FRAC_W, pix_y = accy>>FRAC_W (floor, i.e. rounding).
  - Outputs are held stable while pix_ready=0.
  - On a transfer: if step == last, go to DONE; else add inc to each accumulator and step++.
  - last = 2^n, giving 2^n+1 pixels. When m=0, last = 0 and exactly one pixel is emitted.
  - The final accumulator equals the endpoint exactly.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- start while busy=1 is ignored; there is no queueing.
- pix_ready=1 while pix_valid=0 has no effect.

Optional Feature:
- Macro DDA_DEDUP_EN.
- Defined: in STEP, a computed pixel identical to the previously emitted pixel of the same line is skipped. pix_valid stays 0 for that cycle, the accumulator advances, and the step counter advances. The first pixel is always emitted. If the last step is a duplicate, done still follows.
- Undefined: all 2^n+1 pixels are emitted, duplicates included.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/NORM/STEP/DONE;
  - COORD_W, FRAC_W defaults;
  - derived ACC_W = COORD_W+FRAC_W+1;
  - SHIFT_W = clog2(COORD_W+1).
- One natural sub-module: dda_arith_shift, a combinational signed ACC_W-bit arithmetic right shift by n, instantiated twice (x and y increments).

Test Plan:
- (0,0)->(4,2), pix_ready=1:
  - n=2; pixels (0,0),(1,1),(2,1),(3,2),(4,2);
  - first pix_valid 4 cycles after start; done one cycle after the last transfer.
- (5,5)->(5,5): exactly one pixel (5,5), then done.
- (10,3)->(7,3):
  - without the macro, x sequence 10,9,9,8,7 with y=3 throughout;
  - with DDA_DEDUP_EN, x sequence 10,9,8,7.
- (0,0)->(511,0), COORD_W=9:
  - n=9, 513 transfers, last pixel (511,0);
  - with dedup, 512 pixels, each x value 0..511 exactly once.
- Backpressure: on line (0,0)->(4,2), hold pix_ready=0 for 3 cycles on pixel 2 -> pix_x/pix_y stay (1,1); no pixel is lost or duplicated. start pulsed while busy -> ignored.
- Reset: assert rst during the 3rd pixel of (0,0)->(4,4) -> busy, pix_valid and done drop asynchronously. A new start after release runs a clean line from its own first pixel.
